data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 183 ++++++++++++++++++
 tb/tb_data_memory.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-organised data memory with a fixed multi-cycle BUSYWAIT stall and RV32 load/store sizing.
// Define DMEM_SUBWORD_ACCESS_EN to decode FUNC3 byte/half accesses; otherwise every access is a full aligned word.
//
// state | meaning
// IDLE  | waiting for a request; BUSYWAIT mirrors the request combinationally
// BUSY  | stall counting down; access executes on the edge where the counter is 1
// DONE  | one-cycle completion slot; inputs ignored, MEM_ERR valid
`timescale 1ns/1ps

module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [31:0] MEM_ADDRESS,
    input  logic [31:0] MEM_WRITE_DATA,
    input  logic [2:0]  FUNC3,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MEM_ERR
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    func3_q;
    logic          rd_q;
    logic          wr_q;

    logic          req;
    logic          execute;
    logic [AW-1:0] word_idx;
    logic [31:0]   mem_word;
    logic [31:0]   wr_word;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic          bad;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          unused_addr;
    assign unused_addr = ^MEM_ADDRESS[31:AW+2];

    assign req      = MEM_READ | MEM_WRITE;
    assign execute  = (state == S_BUSY) && (cnt == 4'd1);
    assign word_idx = addr_q[AW+1:2];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = S_BUSY;
            S_BUSY:  if (cnt == 4'd1) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSYWAIT = 1'b0;
        case (state)
            S_IDLE:  BUSYWAIT = req;
            S_BUSY:  BUSYWAIT = 1'b1;
            default: BUSYWAIT = 1'b0;
        endcase
    end

    // Request is captured once; the requester's live inputs are never looked at again.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt     <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            func3_q <= 3'b000;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (state == S_IDLE && req) begin
            cnt     <= CNT_LOAD;
            addr_q  <= MEM_ADDRESS[AW+1:0];
            wdata_q <= MEM_WRITE_DATA;
            func3_q <= FUNC3;
            rd_q    <= MEM_READ;
            wr_q    <= MEM_WRITE;
        end else if (state == S_BUSY) begin
            cnt <= cnt - 4'd1;
        end
    end

`ifdef DMEM_SUBWORD_ACCESS_EN
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        mem_word  = mem[word_idx];
        lane_byte = mem_word[{addr_q[1:0], 3'b000} +: 8];
        lane_half = mem_word[{addr_q[1], 4'b0000} +: 16];
        be        = 4'b0000;
        wr_word   = wdata_q;
        bad       = 1'b0;
        load_val  = mem_word;
        if (wr_q) begin
            case (func3_q)
                3'b000: begin
                    be      = 4'b0001 << addr_q[1:0];
                    wr_word = {4{wdata_q[7:0]}};
                end
                3'b001: begin
                    if (addr_q[0]) bad = 1'b1;
                    else begin
                        be      = 4'b0011 << {addr_q[1], 1'b0};
                        wr_word = {2{wdata_q[15:0]}};
                    end
                end
                3'b010: begin
                    if (addr_q[1:0] != 2'b00) bad = 1'b1;
                    else                      be  = 4'b1111;
                end
                default: bad = 1'b1;
            endcase
        end else begin
            case (func3_q)
                3'b000: load_val = {{24{lane_byte[7]}}, lane_byte};
                3'b001: begin
                    if (addr_q[0]) bad = 1'b1;
                    else           load_val = {{16{lane_half[15]}}, lane_half};
                end
                3'b010: if (addr_q[1:0] != 2'b00) bad = 1'b1;
                3'b100: load_val = {24'h0, lane_byte};
                3'b101: begin
                    if (addr_q[0]) bad = 1'b1;
                    else           load_val = {16'h0, lane_half};
                end
                default: bad = 1'b1;
            endcase
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{func3_q, addr_q[1:0]};

    always_comb begin
        mem_word = mem[word_idx];
        be       = wr_q ? 4'b1111 : 4'b0000;
        wr_word  = wdata_q;
        bad      = 1'b0;
        load_val = mem_word;
    end
`endif

    // Storage has no reset: contents survive RESET, and an aborted access never reaches execute.
    always_ff @(posedge CLK) begin
        if (execute) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            READ_DATA <= 32'h0;
            MEM_ERR   <= 1'b0;
        end else begin
            MEM_ERR <= execute && (bad || (rd_q && wr_q));
            if (execute && rd_q && !wr_q) READ_DATA <= bad ? 32'h0 : load_val;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; expectations follow DMEM_SUBWORD_ACCESS_EN when defined.
`timescale 1ns/1ps

module tb_data_memory;

    localparam int LAT = 5;

`ifdef DMEM_SUBWORD_ACCESS_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    localparam logic [31:0] W10_A   = SUB ? 32'hDEAD7FEF : 32'hAB12347F;
    localparam logic [31:0] W10_B   = SUB ? 32'hDEAD7FEF : 32'h00001111;
    localparam logic [31:0] E_LB11  = SUB ? 32'h0000007F : W10_A;
    localparam logic [31:0] E_LBU13 = SUB ? 32'h000000DE : W10_A;
    localparam logic [31:0] E_LH12  = SUB ? 32'hFFFFDEAD : W10_A;
    localparam logic [31:0] E_LB13  = SUB ? 32'hFFFFFFDE : W10_A;
    localparam logic [31:0] E_LHU10 = SUB ? 32'h00007FEF : W10_A;
    localparam logic [31:0] E_BADRD = SUB ? 32'h00000000 : W10_A;
    localparam logic        E_ERR   = SUB;

    logic        CLK;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITE_DATA;
    logic [2:0]  FUNC3;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MEM_ERR;

    int tests = 0;
    int fails = 0;

    int          n_b, gp;
    logic        eb, e;
    logic [31:0] r;

    data_memory #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_ADDRESS    (MEM_ADDRESS),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .FUNC3          (FUNC3),
        .READ_DATA      (READ_DATA),
        .BUSYWAIT       (BUSYWAIT),
        .MEM_ERR        (MEM_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a request and follows it until the DONE cycle; the request is left held.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] f3, input bit scramble,
                          output int busy_n, output int gap, output logic err_busy,
                          output logic err, output logic [31:0] rdata);
        MEM_READ = rd; MEM_WRITE = wr; MEM_ADDRESS = addr; MEM_WRITE_DATA = data; FUNC3 = f3;
        #1;
        gap = 0; busy_n = 0; err_busy = 1'b0;
        while (!BUSYWAIT && gap < 4) begin
            gap++;
            @(posedge CLK); #2;
        end
        while (BUSYWAIT && busy_n < 40) begin
            busy_n++;
            err_busy = err_busy | MEM_ERR;
            @(posedge CLK); #2;
            if (scramble && busy_n == 1) begin
                MEM_ADDRESS = 32'h14; MEM_WRITE_DATA = ~data; FUNC3 = 3'b011;
            end
        end
        err = MEM_ERR;
        rdata = READ_DATA;
    endtask

    task automatic idle();
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        @(posedge CLK); #2;
    endtask

    task automatic op(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [2:0] f3, input logic exp_err,
                      input bit chk_rd, input logic [31:0] exp_rd);
        int          nb, g;
        logic        ebl, el;
        logic [31:0] rl;
        access(rd, wr, addr, data, f3, 1'b0, nb, g, ebl, el, rl);
        chk({tag, ".busy_cycles"}, 32'(nb), 32'(LAT));
        chk({tag, ".err_while_busy"}, 32'(ebl), 32'h0);
        chk({tag, ".mem_err"}, 32'(el), 32'(exp_err));
        if (chk_rd) chk({tag, ".read_data"}, rl, exp_rd);
        idle();
        chk({tag, ".idle_busywait"}, 32'(BUSYWAIT), 32'h0);
        chk({tag, ".idle_mem_err"}, 32'(MEM_ERR), 32'h0);
    endtask

    initial begin
        RESET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        MEM_ADDRESS = 32'h0; MEM_WRITE_DATA = 32'h0; FUNC3 = 3'b010;
        #12;
        chk("reset.read_data", READ_DATA, 32'h0);
        chk("reset.busywait", 32'(BUSYWAIT), 32'h0);
        chk("reset.mem_err", 32'(MEM_ERR), 32'h0);
        RESET = 1'b1;
        @(posedge CLK); #2;

        op("sw_0x00", 1'b0, 1'b1, 32'h00, 32'h0BADF00D, 3'b010, 1'b0, 1'b0, 32'h0);
        op("sw_0x10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 1'b0, 32'h0);
        chk("sw_keeps_read_data", READ_DATA, 32'h0);
        op("lw_0x10", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("read_data_hold", READ_DATA, 32'hDEADBEEF);

        op("sb_0x11",  1'b0, 1'b1, 32'h11, 32'hAB12347F, 3'b000, 1'b0, 1'b0, 32'h0);
        op("lb_0x11",  1'b1, 1'b0, 32'h11, 32'h0, 3'b000, 1'b0, 1'b1, E_LB11);
        op("lbu_0x13", 1'b1, 1'b0, 32'h13, 32'h0, 3'b100, 1'b0, 1'b1, E_LBU13);
        op("lh_0x12",  1'b1, 1'b0, 32'h12, 32'h0, 3'b001, 1'b0, 1'b1, E_LH12);
        op("lb_0x13",  1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 1'b0, 1'b1, E_LB13);
        op("lhu_0x10", 1'b1, 1'b0, 32'h10, 32'h0, 3'b101, 1'b0, 1'b1, E_LHU10);
        op("lw_0x10_b", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b1, W10_A);

        op("lw_misaligned_0x12", 1'b1, 1'b0, 32'h12, 32'h0, 3'b010, E_ERR, 1'b1, E_BADRD);
        op("ld_func3_011", 1'b1, 1'b0, 32'h10, 32'h0, 3'b011, E_ERR, 1'b1, E_BADRD);
        op("sh_misaligned_0x13", 1'b0, 1'b1, 32'h13, 32'h00001111, 3'b001, E_ERR, 1'b0, 32'h0);
        op("lw_0x10_after_sh", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b1, W10_B);

        op("rd_and_wr_0x14", 1'b1, 1'b1, 32'h14, 32'h600DCAFE, 3'b010, 1'b1, 1'b1, W10_B);
        op("lw_0x14", 1'b1, 1'b0, 32'h14, 32'h0, 3'b010, 1'b0, 1'b1, 32'h600DCAFE);

        access(1'b0, 1'b1, 32'h18, 32'h13579BDF, 3'b010, 1'b1, n_b, gp, eb, e, r);
        chk("sw_scrambled.busy_cycles", 32'(n_b), 32'(LAT));
        chk("sw_scrambled.mem_err", 32'(e), 32'h0);
        idle();
        op("lw_0x18", 1'b1, 1'b0, 32'h18, 32'h0, 3'b010, 1'b0, 1'b1, 32'h13579BDF);
        op("lw_0x14_untouched", 1'b1, 1'b0, 32'h14, 32'h0, 3'b010, 1'b0, 1'b1, 32'h600DCAFE);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b1, n_b, gp, eb, e, r);
        chk("lw_scrambled.read_data", r, W10_B);
        chk("lw_scrambled.mem_err", 32'(e), 32'h0);
        idle();

        op("sw_0x20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 1'b0, 1'b0, 32'h0);
        op("lw_0x20", 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 1'b1, 32'hCAFEF00D);

        MEM_READ = 1'b0; MEM_WRITE = 1'b1; MEM_ADDRESS = 32'h20;
        MEM_WRITE_DATA = 32'h00000055; FUNC3 = 3'b010;
        #1;
        chk("abort.cycle1_busy", 32'(BUSYWAIT), 32'h1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("abort.cycle3_busy", 32'(BUSYWAIT), 32'h1);
        RESET = 1'b0; MEM_WRITE = 1'b0;
        #1;
        chk("abort.busywait_drop", 32'(BUSYWAIT), 32'h0);
        chk("abort.read_data", READ_DATA, 32'h0);
        chk("abort.mem_err", 32'(MEM_ERR), 32'h0);
        repeat (4) @(posedge CLK);
        #2;
        RESET = 1'b1;
        @(posedge CLK); #2;
        op("lw_0x20_after_abort", 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 1'b1, 32'hCAFEF00D);
        op("lw_0x10_retained", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b1, W10_B);

        access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, n_b, gp, eb, e, r);
        chk("b2b_first.busy_cycles", 32'(n_b), 32'(LAT));
        chk("b2b_first.read_data", r, W10_B);
        access(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 1'b0, n_b, gp, eb, e, r);
        chk("b2b_second.gap_cycles", 32'(gp), 32'h1);
        chk("b2b_second.busy_cycles", 32'(n_b), 32'(LAT));
        chk("b2b_second.read_data_wrap", r, 32'h0BADF00D);
        chk("b2b_second.mem_err", 32'(e), 32'h0);
        idle();
        chk("final.busywait", 32'(BUSYWAIT), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
